// File: rtl/uart_cmd_frame_parser_if.sv
// Handshake bundle between the UART byte stream / flash manager and the
// command frame parser. The parser sits on the slave side; whatever feeds it
// bytes and completion pulses uses the master side.
interface uart_cmd_frame_parser_if;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       op_done;
    logic       cmd_rx;
    logic [7:0] addr_rx;
    logic [7:0] data_rx;
    logic       fl_trg;
    logic       busy;
    logic       err;
    logic [1:0] err_code;

    modport master (
        output rx_byte, rx_valid, op_done,
        input  cmd_rx, addr_rx, data_rx, fl_trg, busy, err, err_code
    );

    modport slave (
        input  rx_byte, rx_valid, op_done,
        output cmd_rx, addr_rx, data_rx, fl_trg, busy, err, err_code
    );
endinterface

// File: rtl/uart_cmd_frame_parser.sv
// uart_cmd_frame_parser
// Collects CMD, ADDR, [DATA], [CHK] bytes from the UART receiver into a flash
// request, fires a one-cycle fl_trg and holds the request until the flash
// manager pulses op_done. Flags bad command bytes, inter-byte timeouts and
// overruns on a one-cycle err strobe with a sticky err_code.
//
// Build option: define CHECKSUM_EN to require a trailing XOR checksum byte
// (GET_CHK state, err_code 2'b11 on mismatch). Without it the last payload
// byte goes straight to ISSUE.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | waiting for a command byte, busy=0
// GET_ADDR  | command accepted, waiting for the address byte
// GET_DATA  | write only, waiting for the data byte
// GET_CHK   | CHECKSUM_EN only, waiting for the XOR checksum byte
// ISSUE     | single cycle, fl_trg high with the new request on the outputs
// WAIT_DONE | request held until op_done
//
// err_code: 00 overrun, 01 bad command, 10 inter-byte timeout, 11 checksum.
module uart_cmd_frame_parser #(
    parameter int unsigned TIMEOUT_CYCLES = 500000,
    parameter logic [7:0]  CMD_READ       = 8'h52,
    parameter logic [7:0]  CMD_WRITE      = 8'h57
) (
    input logic                    CLK_50MHZ,
    input logic                    RST,
    uart_cmd_frame_parser_if.slave bus
);

    localparam int unsigned   CW       = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ERR_OVR = 2'b00;
    localparam logic [1:0] ERR_CMD = 2'b01;
    localparam logic [1:0] ERR_TMO = 2'b10;
`ifdef CHECKSUM_EN
    localparam logic [1:0] ERR_CHK = 2'b11;
`endif

`ifdef CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_GET_ADDR  = 3'd1,
        S_GET_DATA  = 3'd2,
        S_ISSUE     = 3'd3,
        S_WAIT_DONE = 3'd4,
        S_GET_CHK   = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_GET_ADDR  = 3'd1,
        S_GET_DATA  = 3'd2,
        S_ISSUE     = 3'd3,
        S_WAIT_DONE = 3'd4
    } state_t;
`endif

    state_t         state_q;
    logic           is_wr_q;
    logic [7:0]     addr_sh_q;
    logic [CW-1:0]  cnt_q;
    logic [CW-1:0]  cnt_d;
    logic           cmd_rx_q;
    logic [7:0]     addr_rx_q;
    logic [7:0]     data_rx_q;
    logic           fl_trg_q;
    logic           busy_q;
    logic           err_q;
    logic [1:0]     err_code_q;
`ifdef CHECKSUM_EN
    logic [7:0]     data_sh_q;
    logic [7:0]     acc_q;
    logic [7:0]     acc_d;
    logic           chk_ok;
`endif

    logic byte_is_wr;
    logic byte_is_cmd;
    logic tmo_hit;

    // Command decode, timeout terminal count and running checksum.
    always_comb begin
        byte_is_wr  = (bus.rx_byte == CMD_WRITE);
        byte_is_cmd = byte_is_wr || (bus.rx_byte == CMD_READ);
        tmo_hit     = (cnt_q == TMO_LAST);
        cnt_d       = cnt_q + CW'(1);
`ifdef CHECKSUM_EN
        acc_d       = acc_q ^ bus.rx_byte;
        chk_ok      = (bus.rx_byte == acc_q);
`endif
    end

    // Frame FSM with registered request, busy and error outputs.
    always_ff @(posedge CLK_50MHZ) begin
        if (!RST) begin
            state_q    <= S_IDLE;
            is_wr_q    <= 1'b0;
            addr_sh_q  <= 8'h00;
            cnt_q      <= '0;
            cmd_rx_q   <= 1'b0;
            addr_rx_q  <= 8'h00;
            data_rx_q  <= 8'h00;
            fl_trg_q   <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
`ifdef CHECKSUM_EN
            data_sh_q  <= 8'h00;
            acc_q      <= 8'h00;
`endif
        end else begin
            fl_trg_q <= 1'b0;
            err_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.rx_valid) begin
                        if (byte_is_cmd) begin
                            is_wr_q <= byte_is_wr;
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                            state_q <= S_GET_ADDR;
`ifdef CHECKSUM_EN
                            acc_q   <= bus.rx_byte;
`endif
                        end else begin
                            err_q      <= 1'b1;
                            err_code_q <= ERR_CMD;
                        end
                    end
                end

                S_GET_ADDR: begin
                    if (bus.rx_valid) begin
                        addr_sh_q <= bus.rx_byte;
                        cnt_q     <= '0;
`ifdef CHECKSUM_EN
                        acc_q     <= acc_d;
`endif
                        if (is_wr_q) begin
                            state_q <= S_GET_DATA;
                        end else begin
`ifdef CHECKSUM_EN
                            state_q <= S_GET_CHK;
`else
                            // Read frame ends here; data_rx keeps its old value.
                            cmd_rx_q  <= 1'b0;
                            addr_rx_q <= bus.rx_byte;
                            fl_trg_q  <= 1'b1;
                            state_q   <= S_ISSUE;
`endif
                        end
                    end else if (tmo_hit) begin
                        err_q      <= 1'b1;
                        err_code_q <= ERR_TMO;
                        busy_q     <= 1'b0;
                        state_q    <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                S_GET_DATA: begin
                    if (bus.rx_valid) begin
                        cnt_q <= '0;
`ifdef CHECKSUM_EN
                        data_sh_q <= bus.rx_byte;
                        acc_q     <= acc_d;
                        state_q   <= S_GET_CHK;
`else
                        cmd_rx_q  <= 1'b1;
                        addr_rx_q <= addr_sh_q;
                        data_rx_q <= bus.rx_byte;
                        fl_trg_q  <= 1'b1;
                        state_q   <= S_ISSUE;
`endif
                    end else if (tmo_hit) begin
                        err_q      <= 1'b1;
                        err_code_q <= ERR_TMO;
                        busy_q     <= 1'b0;
                        state_q    <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

`ifdef CHECKSUM_EN
                S_GET_CHK: begin
                    if (bus.rx_valid) begin
                        cnt_q <= '0;
                        if (chk_ok) begin
                            cmd_rx_q  <= is_wr_q;
                            addr_rx_q <= addr_sh_q;
                            if (is_wr_q) begin
                                data_rx_q <= data_sh_q;
                            end
                            fl_trg_q  <= 1'b1;
                            state_q   <= S_ISSUE;
                        end else begin
                            err_q      <= 1'b1;
                            err_code_q <= ERR_CHK;
                            busy_q     <= 1'b0;
                            state_q    <= S_IDLE;
                        end
                    end else if (tmo_hit) begin
                        err_q      <= 1'b1;
                        err_code_q <= ERR_TMO;
                        busy_q     <= 1'b0;
                        state_q    <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
`endif

                S_ISSUE: begin
                    // op_done is not meaningful yet; a byte here is dropped.
                    if (bus.rx_valid) begin
                        err_q      <= 1'b1;
                        err_code_q <= ERR_OVR;
                    end
                    state_q <= S_WAIT_DONE;
                end

                S_WAIT_DONE: begin
                    if (bus.rx_valid) begin
                        err_q      <= 1'b1;
                        err_code_q <= ERR_OVR;
                    end
                    if (bus.op_done) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_rx   = cmd_rx_q;
    assign bus.addr_rx  = addr_rx_q;
    assign bus.data_rx  = data_rx_q;
    assign bus.fl_trg   = fl_trg_q;
    assign bus.busy     = busy_q;
    assign bus.err      = err_q;
    assign bus.err_code = err_code_q;

endmodule

// File: tb/tb_uart_cmd_frame_parser.sv
// Bench for uart_cmd_frame_parser: directed frames with literal expectations,
// then randomized frames/gaps/overruns/resets, all checked every cycle
// against a frame-level model built on a byte queue.
`timescale 1ns/1ps
module tb_uart_cmd_frame_parser;

    localparam int         T   = 20;
    localparam logic [7:0] CRD = 8'h52;
    localparam logic [7:0] CWR = 8'h57;
`ifdef CHECKSUM_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #10 clk = ~clk;

    uart_cmd_frame_parser_if bus();

    uart_cmd_frame_parser #(.TIMEOUT_CYCLES(T)) dut (
        .CLK_50MHZ(clk),
        .RST      (rst_n),
        .bus      (bus)
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] frame[$];
    int         gap;
    bit         m_issue, m_wait, mdl_on;
    logic       m_cmd, m_trg, m_busy, m_err;
    logic [7:0] m_addr, m_data;
    logic [1:0] m_code;

    initial begin
        mdl_on = 1'b0; m_issue = 1'b0; m_wait = 1'b0; gap = 0;
        m_cmd = 1'b0; m_trg = 1'b0; m_busy = 1'b0; m_err = 1'b0;
        m_addr = 8'h00; m_data = 8'h00; m_code = 2'b00;
    end

    always @(posedge clk) begin
        int         need;
        logic [7:0] x;
        m_trg = 1'b0;
        m_err = 1'b0;
        if (!rst_n) begin
            frame.delete();
            gap = 0; m_issue = 1'b0; m_wait = 1'b0;
            m_cmd = 1'b0; m_addr = 8'h00; m_data = 8'h00; m_busy = 1'b0; m_code = 2'b00;
            mdl_on = 1'b1;
        end else if (m_issue || m_wait) begin
            if (bus.rx_valid) begin
                m_err = 1'b1; m_code = 2'b00;
            end
            if (m_issue) begin
                m_issue = 1'b0; m_wait = 1'b1;
            end else if (bus.op_done) begin
                m_wait = 1'b0; m_busy = 1'b0;
            end
        end else if (frame.size() == 0) begin
            if (bus.rx_valid) begin
                if (bus.rx_byte == CWR || bus.rx_byte == CRD) begin
                    frame.push_back(bus.rx_byte); gap = 0; m_busy = 1'b1;
                end else begin
                    m_err = 1'b1; m_code = 2'b01;
                end
            end
        end else if (bus.rx_valid) begin
            frame.push_back(bus.rx_byte);
            gap  = 0;
            need = ((frame[0] == CWR) ? 3 : 2) + (CHK ? 1 : 0);
            if (frame.size() == need) begin
                x = 8'h00;
                for (int i = 0; i < need - 1; i++) x ^= frame[i];
                if (!CHK || x == frame[need-1]) begin
                    m_cmd  = (frame[0] == CWR);
                    m_addr = frame[1];
                    if (m_cmd) m_data = frame[2];
                    m_trg   = 1'b1;
                    m_issue = 1'b1;
                end else begin
                    m_err = 1'b1; m_code = 2'b11; m_busy = 1'b0;
                end
                frame.delete();
            end
        end else if (gap == T - 1) begin
            m_err = 1'b1; m_code = 2'b10; m_busy = 1'b0;
            frame.delete();
        end else begin
            gap++;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (mdl_on) begin
            check("cmd_rx",   32'(bus.cmd_rx),   32'(m_cmd));
            check("addr_rx",  32'(bus.addr_rx),  32'(m_addr));
            check("data_rx",  32'(bus.data_rx),  32'(m_data));
            check("fl_trg",   32'(bus.fl_trg),   32'(m_trg));
            check("busy",     32'(bus.busy),     32'(m_busy));
            check("err",      32'(bus.err),      32'(m_err));
            check("err_code", 32'(bus.err_code), 32'(m_code));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic v, input logic [7:0] b, input logic od);
        bus.rx_valid = v;
        bus.rx_byte  = b;
        bus.op_done  = od;
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        drive(1'b1, b, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0);
    endtask

    task automatic done_pulse();
        drive(1'b0, 8'h00, 1'b1);
    endtask

    task automatic pick_gap(output int g);
        int r;
        r = int'($urandom_range(0, 19));
        if (r < 14)      g = int'($urandom_range(0, 2));
        else if (r < 17) g = T - 1;
        else if (r < 19) g = T;
        else             g = int'($urandom_range(3, 8));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int         kind, g;
        logic       wr;
        logic [7:0] a, d, c, x;

        bus.rx_valid = 1'b0; bus.rx_byte = 8'h00; bus.op_done = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_cmd",  32'(bus.cmd_rx),   0);
        check("rst_addr", 32'(bus.addr_rx),  0);
        check("rst_busy", 32'(bus.busy),     0);
        check("rst_code", 32'(bus.err_code), 0);
        rst_n = 1'b1;
        idle(2);

        // write 57,3A,C5
        send(8'h57); send(8'h3A); send(8'hC5);
        if (CHK) send(8'hA8);
        check("w_trg",  32'(bus.fl_trg),  1);
        check("w_cmd",  32'(bus.cmd_rx),  1);
        check("w_addr", 32'(bus.addr_rx), 32'h3A);
        check("w_data", 32'(bus.data_rx), 32'hC5);
        check("w_busy", 32'(bus.busy),    1);
        check("mdl_w_addr", 32'(m_addr), 32'h3A);
        check("mdl_w_data", 32'(m_data), 32'hC5);
        idle(3);
        check("w_trg_once", 32'(bus.fl_trg), 0);
        check("w_busy_hold", 32'(bus.busy),  1);
        done_pulse();
        check("w_busy_clr", 32'(bus.busy), 0);

        // read 52,10
        send(8'h52); send(8'h10);
        if (CHK) send(8'h42);
        check("r_trg",  32'(bus.fl_trg),  1);
        check("r_cmd",  32'(bus.cmd_rx),  0);
        check("r_addr", 32'(bus.addr_rx), 32'h10);
        check("r_data", 32'(bus.data_rx), 32'hC5);
        check("mdl_r_data", 32'(m_data), 32'hC5);
        idle(1);
        check("r_trg_once", 32'(bus.fl_trg), 0);
        done_pulse();

        // bad command byte
        send(8'h41);
        check("bad_err",  32'(bus.err),      1);
        check("bad_code", 32'(bus.err_code), 32'h1);
        check("bad_busy", 32'(bus.busy),     0);
        check("bad_trg",  32'(bus.fl_trg),   0);
        idle(1);
        check("bad_err_clr",  32'(bus.err),      0);
        check("bad_code_hold", 32'(bus.err_code), 32'h1);

        // timeout
        send(8'h57);
        idle(T - 1);
        check("tmo_early", 32'(bus.err), 0);
        idle(1);
        check("tmo_err",  32'(bus.err),      1);
        check("tmo_code", 32'(bus.err_code), 32'h2);
        check("tmo_busy", 32'(bus.busy),     0);
        check("mdl_tmo_code", 32'(m_code), 32'h2);

        // byte on the expiry cycle wins
        send(8'h57);
        idle(T - 1);
        send(8'h3A);
        check("exp_err",  32'(bus.err),  0);
        check("exp_busy", 32'(bus.busy), 1);
        send(8'hC5);
        if (CHK) send(8'hA8);
        check("exp_trg", 32'(bus.fl_trg), 1);
        idle(1);
        done_pulse();

        // overrun during WAIT_DONE
        send(8'h57); send(8'h01); send(8'h02);
        if (CHK) send(8'h54);
        idle(1);
        send(8'h99);
        check("ovr_err",  32'(bus.err),      1);
        check("ovr_code", 32'(bus.err_code), 0);
        check("ovr_addr", 32'(bus.addr_rx),  32'h01);
        check("ovr_data", 32'(bus.data_rx),  32'h02);
        check("ovr_busy", 32'(bus.busy),     1);
        done_pulse();
        check("ovr_done", 32'(bus.busy), 0);

`ifdef CHECKSUM_EN
        send(8'h52); send(8'h10); send(8'h00);
        check("chk_err",  32'(bus.err),      1);
        check("chk_code", 32'(bus.err_code), 32'h3);
        check("chk_trg",  32'(bus.fl_trg),   0);
        check("chk_busy", 32'(bus.busy),     0);
        idle(1);
`endif

        // reset mid-frame
        send(8'h57); send(8'h3A);
        rst_n = 1'b0;
        idle(1);
        check("mrst_busy", 32'(bus.busy),    0);
        check("mrst_addr", 32'(bus.addr_rx), 0);
        check("mrst_data", 32'(bus.data_rx), 0);
        check("mrst_cmd",  32'(bus.cmd_rx),  0);
        rst_n = 1'b1;
        send(8'h52); send(8'h20);
        if (CHK) send(8'h72);
        check("prst_trg",  32'(bus.fl_trg),  1);
        check("prst_addr", 32'(bus.addr_rx), 32'h20);
        check("prst_data", 32'(bus.data_rx), 0);
        done_pulse();
        idle(2);

        // randomized frames, gaps, overruns, stray op_done and resets
        for (int f = 0; f < 200; f++) begin
            kind = int'($urandom_range(0, 9));
            if (kind == 0) begin
                send(8'($urandom));
            end else begin
                wr = 1'($urandom_range(0, 1));
                c  = wr ? CWR : CRD;
                a  = 8'($urandom);
                d  = 8'($urandom);
                x  = c ^ a ^ (wr ? d : 8'h00);
                pick_gap(g); idle(g); send(c);
                pick_gap(g); idle(g); send(a);
                if (wr) begin
                    pick_gap(g); idle(g); send(d);
                end
                if (CHK) begin
                    pick_gap(g); idle(g);
                    send(($urandom_range(0, 7) == 0) ? (x ^ 8'h01) : x);
                end
            end
            idle(int'($urandom_range(0, 3)));
            if ($urandom_range(0, 3) == 0) send(8'($urandom));
            if ($urandom_range(0, 5) == 0) done_pulse();
            idle(int'($urandom_range(0, 2)));
            done_pulse();
            idle(int'($urandom_range(0, 4)));
            if ($urandom_range(0, 29) == 0) begin
                rst_n = 1'b0;
                idle(1);
                rst_n = 1'b1;
            end
        end

        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/uart_cmd_frame_parser.md
Name: uart_cmd_frame_parser

Overview:
- Upstream stage of the flash manager FSM.
- Assembles serial command frames from the UART receiver byte stream into a flash request: cmd_rx, addr_rx, data_rx and a single-cycle fl_trg.
- Keeps the request stable until the manager reports completion.
- Detects bad command bytes, inter-byte timeouts, overruns and (optionally) checksum errors.

Parameters:
- TIMEOUT_CYCLES, 500000, max clock cycles between consecutive bytes of one frame (10 ms at 50 MHz); legal range ≥ 2.
- CMD_READ, 8'h52, command byte for a read ('R').
- CMD_WRITE, 8'h57, command byte for a write ('W').

Ports:
- CLK_50MHZ  in  1  system clock; all logic on rising edge.
- RST  in  1  synchronous, active-low reset.
- rx_byte  in  8  received byte; valid only with rx_valid.
- rx_valid  in  1  one-cycle strobe per received byte.
- op_done  in  1  completion pulse from the flash manager (its tx_trig).
- cmd_rx  out  1  request type: 1 = write, 0 = read.
- addr_rx  out  8  flash address.
- data_rx  out  8  write data.
- fl_trg  out  1  one-cycle request strobe to the flash manager.
- busy  out  1  high from frame start to op_done.
- err  out  1  one-cycle error strobe.
- err_code  out  2  error cause; valid with err, held until the next err.

Behaviour:
- Reset (RST=0 at a clock edge):
  - state=IDLE.
  - cmd_rx=0, addr_rx=0, data_rx=0, fl_trg=0, busy=0, err=0, err_code=0.
  - Timeout counter = 0; shadow registers = 0.
  - Applies mid-frame and mid-operation; any in-flight frame is discarded with no err.
- Frame format: CMD, ADDR, DATA (write only), then CHK when CHECKSUM_EN.
- States:
  - IDLE: busy=0. On rx_valid:
    - rx_byte == CMD_WRITE or CMD_READ: latch the type in the shadow, go to GET_ADDR.
    - Any other byte: err=1, err_code=2'b01, stay in IDLE.
  - GET_ADDR: on rx_valid, latch the shadow address. Next state is GET_DATA for a write, otherwise GET_CHK (if enabled) or ISSUE.
  - GET_DATA: on rx_valid, latch the shadow data. Next state is GET_CHK (if enabled) or ISSUE.
  - GET_CHK: see Optional Feature.
  - ISSUE: exactly one cycle.
    - Copy shadows to cmd_rx/addr_rx/data_rx; these outputs are registered and change only on this transition.
    - For a read, data_rx keeps its previous value.
    - fl_trg=1 in this cycle, coincident with the new output values. Latency: fl_trg is asserted the cycle after the last frame byte's rx_valid.
    - Go to WAIT_DONE.
  - WAIT_DONE: hold all outputs. op_done → IDLE; busy deasserts the cycle after op_done. There is no timeout; only reset or op_done leaves this state.
- busy: 1 in every state except IDLE.
- Timeout (GET_ADDR/GET_DATA/GET_CHK):
  - Counter clears on entering the state and on every rx_valid; otherwise increments.
  - When the counter reaches TIMEOUT_CYCLES-1 with no rx_valid: err=1, err_code=2'b10, discard the frame, go to IDLE.
  - rx_valid in the expiry cycle: the byte wins, no error.
- Overrun: rx_valid in ISSUE or WAIT_DONE drops the byte, err=1, err_code=2'b00. State and outputs are unaffected.
- op_done outside WAIT_DONE is ignored.
- err is never asserted for two causes in the same cycle; at most one rx_valid is handled per cycle.

Optional Feature:
- Macro: CHECKSUM_EN.
- Defined:
  - GET_CHK state exists. CHK must equal the XOR of all preceding frame bytes.
  - Match → ISSUE.
  - Mismatch → err=1, err_code=2'b11, frame discarded, IDLE, no fl_trg.
- Undefined:
  - GET_CHK state and XOR accumulator are absent.
  - The last payload byte goes directly to ISSUE.
  - err_code 2'b11 is never produced.

Test Plan:
- Write frame 57,3A,C5 (+ CHK 57^3A^C5=A8 when enabled) → fl_trg pulse one cycle after the last byte; cmd_rx=1, addr_rx=3A, data_rx=C5; busy=1 until op_done; then busy=0.
- Read frame 52,10 (+ CHK 42) after the write above → cmd_rx=0, addr_rx=10, data_rx stays C5, single fl_trg.
- Byte 41 in IDLE → err=1, err_code=01, no fl_trg, busy=0.
- 57 then silence for TIMEOUT_CYCLES (test value 20) → err, err_code=10, return to IDLE; a byte arriving on the expiry cycle instead → no err.
- Byte during WAIT_DONE → err_code=00; outputs unchanged; a later op_done still returns to IDLE.
- CHECKSUM_EN: frame 52,10,00 → err_code=11, no fl_trg. Also: RST=0 mid-frame → all outputs 0, next valid frame parsed normally.
